sram_mem_controller: RTL and testbench

- Sits directly downstream of the MEM stage and owns the external 16-bit SRAM data memory.
- Converts each 32-bit load/store from the MEM stage into two 16-bit SRAM half-word accesses.
- Drives `ready` low while an access is in flight. The top level uses `ready` to freeze every pipeline register.
- Replaces the single-cycle behavioural data memory.

---
 rtl/sram_mem_controller.sv | 124 ++++++++++++
 tb/tb_sram_mem_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Bridges 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as two half-word phases.
// Define SRAM_MEM_BASE_OFFSET_EN to map byte address 1024 onto SRAM half-word 0.
module sram_mem_controller #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  counter_reg, counter_next;
    logic        op_write_reg;
    logic [16:0] idx_reg;
    logic [31:0] wdata_reg;

    logic [31:0] eff;
    logic        req;
    logic        last_cycle;
    logic        in_phase;
    logic        dq_oe;
    logic [15:0] dq_out;

`ifdef SRAM_MEM_BASE_OFFSET_EN
    assign eff = address - 32'd1024;
`else
    assign eff = address;
`endif

    // Byte-lane and out-of-range address bits carry no meaning for this memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{eff[31:19], eff[1:0]};

    assign req        = wr_en | rd_en;
    assign last_cycle = (counter_reg == LAST_COUNT);
    assign in_phase   = (state_reg == LOW) || (state_reg == HIGH);

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next   = LOW;
                    counter_next = 4'd0;
                end
            end
            LOW: begin
                if (last_cycle) begin
                    state_next   = HIGH;
                    counter_next = 4'd0;
                end else begin
                    counter_next = counter_reg + 4'd1;
                end
            end
            HIGH: begin
                if (last_cycle) begin
                    state_next   = DONE;
                    counter_next = 4'd0;
                end else begin
                    counter_next = counter_reg + 4'd1;
                end
            end
            DONE: state_next = IDLE;
            default: begin
                state_next   = IDLE;
                counter_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            counter_reg  <= 4'd0;
            op_write_reg <= 1'b0;
            idx_reg      <= '0;
            wdata_reg    <= '0;
            read_data    <= '0;
            SRAM_ADDR    <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            if (state_reg == IDLE && req) begin
                op_write_reg <= wr_en;
                idx_reg      <= eff[18:2];
                wdata_reg    <= write_data;
                SRAM_ADDR    <= {eff[18:2], 1'b0};
            end
            if (state_reg == LOW && last_cycle)
                SRAM_ADDR <= {idx_reg, 1'b1};
            // The bus has settled for WAIT_CYCLES-1 cycles by the last cycle of a read phase.
            if (!op_write_reg && in_phase && last_cycle) begin
                if (state_reg == LOW)
                    read_data[15:0] <= SRAM_DQ;
                else
                    read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    // WE_N rises in the final phase cycle so the write commits with address and data still held.
    assign SRAM_WE_N = !(op_write_reg && in_phase && !last_cycle);
    assign SRAM_OE_N = !(!op_write_reg && in_phase);
    assign dq_oe     = op_write_reg && in_phase;
    assign dq_out    = (state_reg == LOW) ? wdata_reg[15:0] : wdata_reg[31:16];
    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

    assign ready = ((state_reg == IDLE) && !req) || (state_reg == DONE);

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: vector table plus reset and offset sequences,
// with a behavioural 16-bit SRAM that commits on the rising edge of WE_N.
module tb_sram_mem_controller;

    localparam int W = 2;
`ifdef SRAM_MEM_BASE_OFFSET_EN
    localparam logic [31:0] OFS = 32'd1024;
`else
    localparam logic [31:0] OFS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_OE_N;

    sram_mem_controller #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus while OE_N is low, latches on WE_N rising outside reset.
    logic [15:0] sram [0:255];
    logic [15:0] sram_rd;
    assign sram_rd = sram[SRAM_ADDR[7:0]];
    assign SRAM_DQ = (!SRAM_OE_N) ? sram_rd : 16'hzzzz;

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
        sram[10] = 16'h5678;
        sram[11] = 16'h1234;
        forever begin
            @(posedge SRAM_WE_N);
            if (rst === 1'b1) sram[SRAM_ADDR[7:0]] = SRAM_DQ;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Counts the frozen cycles of one access and scores it once DONE is reached.
    task automatic wait_done(input string name, input logic is_write);
        int lat, we_lo, oe_lo;
        logic [31:0] exp;
        lat = 0; we_lo = 0; oe_lo = 0;
        while (!ready && lat < 200) begin
            if (!SRAM_WE_N) we_lo++;
            if (!SRAM_OE_N) oe_lo++;
            @(negedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, 2 * W + 1);
        check({name, " we_low_cycles"}, we_lo, is_write ? 2 * (W - 1) : 0);
        check({name, " oe_low_cycles"}, oe_lo, is_write ? 0 : 2 * W);
        if (exp_q.size() == 0) begin
            check({name, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check({name, " read_data"}, read_data, exp);
        end
        $display("txn %s: frozen %0d cycles, read_data=%h", name, lat, read_data);
    endtask

    task automatic run_txn(input string name, input logic w, input logic r,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; write_data = d;
        exp_q.push_back(exp_rd);
        #1;
        wait_done(name, w);
    endtask

    // Drop the request in the cycle after DONE; the FSM must be back in IDLE, not re-issuing.
    task automatic drop_req(input string name);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
        check({name, " idle_after_done"}, ready, 1'b1);
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic        r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        b2b;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"store_10",     1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{"load_10",      1'b0, 1'b1, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{"store_18_b2b", 1'b1, 1'b0, 32'h0000_0018, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{"load_14_b2b",  1'b0, 1'b1, 32'h0000_0014, 32'h0,        32'h1234_5678, 1'b0};
        vecs[4] = '{"load_18",      1'b0, 1'b1, 32'h0000_0018, 32'h0,        32'hCAFE_F00D, 1'b0};
        vecs[5] = '{"both_20",      1'b1, 1'b1, 32'h0000_0020, 32'h0000_00AA, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{"load_20",      1'b0, 1'b1, 32'h0000_0020, 32'h0,        32'h0000_00AA, 1'b0};
        vecs[7] = '{"load_hi_bits", 1'b0, 1'b1, 32'hFFF8_0022, 32'h0,        32'h0000_00AA, 1'b0};

        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset ready", ready, 1'b1);
        check("reset we_n", SRAM_WE_N, 1'b1);
        check("reset oe_n", SRAM_OE_N, 1'b1);
        check("reset sram_addr", 32'(SRAM_ADDR), 32'd0);
        check("reset read_data", read_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].name, vecs[i].w, vecs[i].r, vecs[i].addr + OFS,
                    vecs[i].wdata, vecs[i].exp_rd);
            if (!vecs[i].b2b) drop_req(vecs[i].name);
        end

        check("mem hw8",  32'(sram[8]),  32'h0000_BEEF);
        check("mem hw9",  32'(sram[9]),  32'h0000_DEAD);
        check("mem hw12", 32'(sram[12]), 32'h0000_F00D);
        check("mem hw13", 32'(sram[13]), 32'h0000_CAFE);
        check("mem hw16", 32'(sram[16]), 32'h0000_00AA);
        check("mem hw17", 32'(sram[17]), 32'h0000_0000);

        // Reset during the first HIGH cycle of a store to 0x30 (half-words 24/25).
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; address = 32'h0000_0030 + OFS; write_data = 32'hA5A5_5A5A;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid high_phase we_n", SRAM_WE_N, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_mid we_n", SRAM_WE_N, 1'b1);
        check("rst_mid oe_n", SRAM_OE_N, 1'b1);
        check("rst_mid sram_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_mid read_data", read_data, 32'd0);
        check("rst_mid ready", ready, 1'b0);
        check("rst_mid hw24", 32'(sram[24]), 32'h0000_5A5A);
        check("rst_mid hw25", 32'(sram[25]), 32'h0000_0000);
        $display("txn rst_mid: reset asserted in HIGH phase");
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(32'd0);
        #1;
        wait_done("rst_restart", 1'b1);
        drop_req("rst_restart");
        check("rst_restart hw24", 32'(sram[24]), 32'h0000_5A5A);
        check("rst_restart hw25", 32'(sram[25]), 32'h0000_A5A5);

`ifdef SRAM_MEM_BASE_OFFSET_EN
        run_txn("store_base", 1'b1, 1'b0, 32'd1024, 32'h0102_0304, 32'd0);
        drop_req("store_base");
        check("base hw0", 32'(sram[0]), 32'h0000_0304);
        check("base hw1", 32'(sram[1]), 32'h0000_0102);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
